// File: rtl/systolic_feeder.sv
// Operand store and diagonal-skew streamer for an NxN systolic array.
// Holds A and B, clears the array, streams skewed lanes, waits for array_done, pulses done.
module systolic_feeder #(
   parameter  int N  = 4,
   parameter  int DW = 32,
   localparam int AW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic            wr_mat,
   input  logic [AW-1:0]   wr_row,
   input  logic [AW-1:0]   wr_col,
   input  logic [DW-1:0]   wr_data,
   input  logic            start,
   output logic            busy,
   output logic            arr_clr,
   output logic [N*DW-1:0] west_bus,
   output logic [N*DW-1:0] north_bus,
   input  logic            array_done,
   output logic            done
);

   localparam int TW = $clog2(2 * N);
   localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [TW-1:0]     t_q;
   logic              busy_q;
   logic              arr_clr_q;
   logic              done_q;
   logic [N*DW-1:0]   west_q;
   logic [N*DW-1:0]   north_q;

   logic [DW-1:0]     a_q [N][N];
   logic [DW-1:0]     b_q [N][N];

   logic              idx_ok;
   logic [TW-1:0]     t_sel;
   logic [N*DW-1:0]   west_d;
   logic [N*DW-1:0]   north_d;

   // Indices wrap cleanly when N is a power of two, so only other sizes need a range check.
   generate
      if (N == (1 << AW)) begin : g_pow2
         assign idx_ok = 1'b1;
      end else begin : g_npow2
         assign idx_ok = (int'(wr_row) < N) && (int'(wr_col) < N);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               a_q[r][c] <= '0;
               b_q[r][c] <= '0;
            end
         end
      end else if (wr_en && (state_q == S_IDLE) && idx_ok) begin
         if (wr_mat) b_q[wr_row][wr_col] <= wr_data;
         else        a_q[wr_row][wr_col] <= wr_data;
      end
   end

   // Lane values for the step about to be presented: t=0 leaving CLEAR, t+1 inside STREAM.
   assign t_sel = (state_q == S_CLEAR) ? '0 : t_q + 1'b1;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         logic [TW:0] w_diff;
         logic        w_ok;
         assign w_diff = {1'b0, t_sel} - (TW + 1)'(gi);
         assign w_ok   = ({1'b0, t_sel} >= (TW + 1)'(gi)) && (w_diff < (TW + 1)'(N));
         assign west_d[gi*DW +: DW]  = w_ok ? a_q[gi][w_diff[AW-1:0]] : '0;
         assign north_d[gi*DW +: DW] = w_ok ? b_q[w_diff[AW-1:0]][gi] : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         t_q       <= '0;
         busy_q    <= 1'b0;
         arr_clr_q <= 1'b0;
         done_q    <= 1'b0;
         west_q    <= '0;
         north_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q   <= S_CLEAR;
                  busy_q    <= 1'b1;
                  arr_clr_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               state_q   <= S_STREAM;
               t_q       <= '0;
               arr_clr_q <= 1'b0;
               west_q    <= west_d;
               north_q   <= north_d;
            end
            S_STREAM: begin
               if (t_q == T_LAST) begin
                  state_q <= S_WAIT;
                  west_q  <= '0;
                  north_q <= '0;
               end else begin
                  t_q     <= t_q + 1'b1;
                  west_q  <= west_d;
                  north_q <= north_d;
               end
            end
            S_WAIT: begin
               if (array_done) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               arr_clr_q <= 1'b0;
               done_q    <= 1'b0;
               west_q    <= '0;
               north_q   <= '0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign arr_clr   = arr_clr_q;
   assign done      = done_q;
   assign west_bus  = west_q;
   assign north_bus = north_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder against a matrix-level skew model.
module tb_systolic_feeder;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = $clog2(N);
   localparam int BW = N * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic          wr_mat = 1'b0;
   logic [AW-1:0] wr_row = '0;
   logic [AW-1:0] wr_col = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          array_done = 1'b0;
   logic          busy, arr_clr, done;
   logic [BW-1:0] west_bus, north_bus;

   int errors = 0;
   int checks = 0;

   // Reference matrices: ma[i][k] is A, mb[k][j] is B.
   logic [DW-1:0] ma [N][N];
   logic [DW-1:0] mb [N][N];

   systolic_feeder #(.N(N), .DW(DW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mat(wr_mat), .wr_row(wr_row),
      .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy),
      .arr_clr(arr_clr), .west_bus(west_bus), .north_bus(north_bus),
      .array_done(array_done), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // West lane i at stream step t carries row i of A, delayed by i steps.
   function automatic logic [BW-1:0] exp_west(input int t);
      logic [BW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
      return v;
   endfunction

   // North lane j at stream step t carries column j of B, delayed by j steps.
   function automatic logic [BW-1:0] exp_north(input int t);
      logic [BW-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
      return v;
   endfunction

   task automatic write_elem(input bit m, input int r, input int c, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_mat = m; wr_row = AW'(r); wr_col = AW'(c); wr_data = d;
      tick();
      wr_en = 1'b0;
      if (m) mb[r][c] = d;
      else   ma[r][c] = d;
   endtask

   task automatic clear_model();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
         end
   endtask

   // One full job; caller may pre-drive a write alongside start.
   task automatic run_job(input int job, input int delay, input bit hold_done, input bit poke_busy);
      start = 1'b1;
      if (hold_done) array_done = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      check_eq($sformatf("j%0d clr", job), BW'(arr_clr), BW'(1));
      check_eq($sformatf("j%0d busy_clr", job), BW'(busy), BW'(1));
      check_eq($sformatf("j%0d west_clr", job), west_bus, '0);
      check_eq($sformatf("j%0d north_clr", job), north_bus, '0);
      for (int t = 0; t < 2 * N - 1; t++) begin
         if (poke_busy && t == 1) begin
            wr_en = 1'b1; wr_mat = 1'b0; wr_row = '0; wr_col = '0; wr_data = 99;
            start = 1'b1;
         end
         tick();
         wr_en = 1'b0;
         start = 1'b0;
         check_eq($sformatf("j%0d west t=%0d", job, t), west_bus, exp_west(t));
         check_eq($sformatf("j%0d north t=%0d", job, t), north_bus, exp_north(t));
         check_eq($sformatf("j%0d ctl t=%0d", job, t), BW'({busy, arr_clr, done}), BW'(3'b100));
      end
      tick();
      check_eq($sformatf("j%0d wait buses", job), west_bus | north_bus, '0);
      check_eq($sformatf("j%0d wait ctl", job), BW'({busy, done}), BW'(2'b10));
      if (!hold_done) begin
         for (int d = 0; d < delay; d++) begin
            tick();
            check_eq($sformatf("j%0d hold %0d", job, d), BW'({busy, done}), BW'(2'b10));
         end
         array_done = 1'b1;
      end
      tick();
      array_done = 1'b0;
      check_eq($sformatf("j%0d done", job), BW'({busy, done}), BW'(2'b11));
      tick();
      check_eq($sformatf("j%0d after", job), BW'({busy, done}), BW'(2'b00));
      $display("job %0d complete: delay=%0d hold=%0d poke=%0d", job, delay, hold_done, poke_busy);
   endtask

   initial begin
      clear_model();
      // Reset held with start asserted must keep everything quiet.
      start = 1'b1;
      repeat (3) tick();
      check_eq("rst ctl", BW'({busy, arr_clr, done}), BW'(3'b000));
      check_eq("rst buses", west_bus | north_bus, '0);
      start = 1'b0;
      rst = 1'b1;
      tick();
      check_eq("post rst busy", BW'(busy), BW'(0));

      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) write_elem(1'b0, i, k, DW'(4 * i + 3 - k));
      for (int k = 0; k < N; k++)
         for (int j = 0; j < N; j++) write_elem(1'b1, k, j, DW'(12 - 4 * k + j));

      run_job(0, 10, 1'b0, 1'b1);
      tick();
      check_eq("no second job", BW'(busy), BW'(0));
      run_job(1, 2, 1'b0, 1'b0);

      // Write and start in the same idle cycle: the stream sees the new value.
      wr_en = 1'b1; wr_mat = 1'b0; wr_row = '0; wr_col = '0; wr_data = 5;
      ma[0][0] = 5;
      run_job(2, 0, 1'b1, 1'b0);

      for (int job = 3; job < 7; job++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               write_elem(1'b0, r, c, DW'($urandom));
               write_elem(1'b1, r, c, DW'($urandom));
            end
         run_job(job, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a stream wipes state and storage.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 4; t++) tick();
      check_eq("pre-abort west t=3", west_bus, exp_west(3));
      rst = 1'b0;
      #1;
      check_eq("abort ctl", BW'({busy, arr_clr, done}), BW'(3'b000));
      check_eq("abort buses", west_bus | north_bus, '0);
      tick();
      rst = 1'b1;
      tick();
      check_eq("abort idle", BW'(busy), BW'(0));
      clear_model();
      run_job(7, 1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
